// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, fetch entry layout and PC helper for the instruction fetch unit.
package instr_fetch_unit_pkg;
   localparam int ADDR_W = 12;
   localparam int INST_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Sequential fetch wraps silently at the top of the address space.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, control and decode-handshake signals of the fetch unit.
interface instr_fetch_unit_if;
   import instr_fetch_unit_pkg::*;

   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_data, redirect_valid, redirect_pc, halt, inst_ready
   );

   modport slave (
      input  imem_addr, inst_valid, inst_data, inst_pc,
      output imem_data, redirect_valid, redirect_pc, halt, inst_ready
   );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with push/pop/flush; flush wins.
module instr_fetch_unit_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  fetch_entry_t           i_data,
   output fetch_entry_t           o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);
   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == (PW+1)'(DEPTH));
   // Guards keep count inside [0, DEPTH] even if the caller misbehaves.
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~w_full | w_pop);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: drives ROM address, queues returned words, handles redirect/halt.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   instr_fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [CW-1:0]     w_count;
   logic              w_empty;
   logic              w_deq;
   logic              w_room;
   logic              w_enq;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head;

   assign w_deq  = ~w_empty & bus.inst_ready;
   // A full FIFO still accepts a new word when the head leaves this cycle.
   assign w_room = (w_count < CW'(DEPTH)) | w_deq;
   assign w_enq  = ~bus.halt & ~bus.redirect_valid & w_room;

   assign w_push_entry.addr = r_fetch_pc;
   assign w_push_entry.inst = bus.imem_data;

   instr_fetch_unit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_enq),
      .i_pop   (w_deq),
      .i_flush (bus.redirect_valid),
      .i_data  (w_push_entry),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_fetch_pc <= RESET_PC;
      else if (bus.redirect_valid) r_fetch_pc <= bus.redirect_pc;
      else if (w_enq)              r_fetch_pc <= pc_inc(r_fetch_pc);
   end

   assign bus.imem_addr  = r_fetch_pc;
   assign bus.inst_valid = ~w_empty;
   // Decode never sees stale entry contents while nothing is valid.
   assign bus.inst_data  = w_empty ? '0 : w_head.inst;
   assign bus.inst_pc    = w_empty ? '0 : w_head.addr;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based reference model.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (12'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom(input logic [11:0] a);
      case (a)
         12'd0:         return 16'h0008;
         12'd8:         return 16'hE000;
         12'd9, 12'd10: return 16'h1001;
         default:       return 16'h0000;
      endcase
   endfunction

   always_comb bus.imem_data = rom(bus.imem_addr);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: a queue of fetched {pc, word} pairs plus the next fetch address.
   typedef struct {
      logic [11:0] pc;
      logic [15:0] inst;
   } ment_t;

   ment_t       mq[$];
   logic [11:0] m_pc = 12'd0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_pc = 12'd0;
      end else if (bus.redirect_valid) begin
         mq.delete();
         m_pc = bus.redirect_pc;
      end else begin
         if (mq.size() > 0 && bus.inst_ready) void'(mq.pop_front());
         if (!bus.halt && mq.size() < DEPTH) begin
            mq.push_back('{m_pc, rom(m_pc)});
            m_pc = m_pc + 12'd1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
      chk("cyc_pc",    32'(bus.inst_pc),    32'(mq.size() > 0 ? mq[0].pc : 12'd0));
      chk("cyc_data",  32'(bus.inst_data),  32'(mq.size() > 0 ? mq[0].inst : 16'd0));
      chk("cyc_addr",  32'(bus.imem_addr),  32'(m_pc));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_head(input string nm, input logic v, input logic [11:0] pc,
                              input logic [15:0] d, input logic [11:0] addr);
      chk({nm, "_valid"}, 32'(bus.inst_valid), 32'(v));
      chk({nm, "_pc"},    32'(bus.inst_pc),    32'(pc));
      chk({nm, "_data"},  32'(bus.inst_data),  32'(d));
      chk({nm, "_addr"},  32'(bus.imem_addr),  32'(addr));
   endtask

   initial begin
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 12'd0;
      bus.inst_ready     = 1'b1;

      // 1: reset state, then one word per cycle in address order
      step();
      expect_head("rst", 1'b0, 12'd0, 16'h0000, 12'd0);
      rst = 1'b0;
      step(); expect_head("s1_c1", 1'b1, 12'd0, 16'h0008, 12'd1);
      step(); expect_head("s1_c2", 1'b1, 12'd1, 16'h0000, 12'd2);
      step(); expect_head("s1_c3", 1'b1, 12'd2, 16'h0000, 12'd3);

      // 2: redirect with two entries queued
      bus.inst_ready = 1'b0;
      step(); expect_head("s2_fill", 1'b1, 12'd2, 16'h0000, 12'd4);
      bus.inst_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd8;
      step(); expect_head("s2_flush", 1'b0, 12'd0, 16'h0000, 12'd8);
      bus.redirect_valid = 1'b0;
      step(); expect_head("s2_t8",  1'b1, 12'd8,  16'hE000, 12'd9);
      step(); expect_head("s2_t9",  1'b1, 12'd9,  16'h1001, 12'd10);
      step(); expect_head("s2_t10", 1'b1, 12'd10, 16'h1001, 12'd11);

      // 3: back-pressure from reset
      rst = 1'b1; bus.inst_ready = 1'b0;
      step(); rst = 1'b0;
      step(); expect_head("s3_f1",    1'b1, 12'd0, 16'h0008, 12'd1);
      step(); expect_head("s3_full",  1'b1, 12'd0, 16'h0008, 12'd2);
      step(); expect_head("s3_stall", 1'b1, 12'd0, 16'h0008, 12'd2);
      bus.inst_ready = 1'b1;
      step(); expect_head("s3_p1", 1'b1, 12'd1, 16'h0000, 12'd3);
      step(); expect_head("s3_p2", 1'b1, 12'd2, 16'h0000, 12'd4);
      step(); expect_head("s3_p3", 1'b1, 12'd3, 16'h0000, 12'd5);

      // 4: halt drains the queue and holds PC; redirect still applies under halt
      rst = 1'b1; bus.inst_ready = 1'b0;
      step(); rst = 1'b0;
      step();
      step(); expect_head("s4_full", 1'b1, 12'd0, 16'h0008, 12'd2);
      bus.halt = 1'b1; bus.inst_ready = 1'b1;
      step(); expect_head("s4_d1",   1'b1, 12'd1, 16'h0000, 12'd2);
      step(); expect_head("s4_d2",   1'b0, 12'd0, 16'h0000, 12'd2);
      step(); expect_head("s4_idle", 1'b0, 12'd0, 16'h0000, 12'd2);
      bus.halt = 1'b0;
      step(); expect_head("s4_resume", 1'b1, 12'd2, 16'h0000, 12'd3);
      bus.halt = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd9;
      step(); expect_head("s4_hredir", 1'b0, 12'd0, 16'h0000, 12'd9);
      bus.redirect_valid = 1'b0;
      step(); expect_head("s4_hhold", 1'b0, 12'd0, 16'h0000, 12'd9);
      bus.halt = 1'b0;
      step(); expect_head("s4_hres", 1'b1, 12'd9, 16'h1001, 12'd10);

      // 5: wrap at the top of the address space
      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd4095;
      step(); expect_head("s5_flush", 1'b0, 12'd0, 16'h0000, 12'd4095);
      bus.redirect_valid = 1'b0;
      step(); expect_head("s5_top",  1'b1, 12'd4095, 16'h0000, 12'd0);
      step(); expect_head("s5_wrap", 1'b1, 12'd0,    16'h0008, 12'd1);

      // 6: asynchronous reset with a full FIFO
      bus.inst_ready = 1'b0;
      step(); expect_head("s6_full", 1'b1, 12'd0, 16'h0008, 12'd2);
      rst = 1'b1;
      #1;
      expect_head("s6_async", 1'b0, 12'd0, 16'h0000, 12'd0);
      step();
      rst = 1'b0; bus.inst_ready = 1'b1;
      step(); expect_head("s6_c1", 1'b1, 12'd0, 16'h0008, 12'd1);
      step(); expect_head("s6_c2", 1'b1, 12'd1, 16'h0000, 12'd2);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
